// File: rtl/pulse_sched.sv
// Multi-channel pulse delay/stretch engine: per-channel delay D, width W and retrigger policy.
// Define PULSE_SCHED_OVR_EN to build the sticky per-channel overrun flags.
module pulse_sched #(
  parameter int unsigned CH    = 4,
  parameter int unsigned DLY_W = 8,
  parameter int unsigned WID_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         d,
  input  logic [CH*DLY_W-1:0]   dly,
  input  logic [CH*WID_W-1:0]   wid,
  input  logic [CH-1:0]         retrig,
  input  logic [CH-1:0]         ovr_clr,
  output logic [CH-1:0]         q,
  output logic [CH-1:0]         busy,
  output logic [CH-1:0]         ovr
);

  localparam int unsigned CntW = (DLY_W > WID_W) ? DLY_W : WID_W;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StActive
  } state_e;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_e            state;
    logic [CntW-1:0]   cnt;
    logic [WID_W-1:0]  wid_lat;
    logic              q_r;
    logic              busy_r;
    logic [DLY_W-1:0]  dly_i;
    logic [WID_W-1:0]  wid_i;
    logic              trig;
    logic              accept;

    assign dly_i = dly[i*DLY_W +: DLY_W];
    assign wid_i = wid[i*WID_W +: WID_W];

    // Zero-width triggers are invisible in every state.
    assign trig   = d[i] && (wid_i != '0);
    assign accept = trig && ((state == StIdle) || retrig[i]);

    // Only W needs holding: D is consumed into cnt at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= StIdle;
        cnt     <= '0;
        wid_lat <= '0;
        q_r     <= 1'b0;
        busy_r  <= 1'b0;
      end else if (accept) begin
        wid_lat <= wid_i;
        busy_r  <= 1'b1;
        if (dly_i == '0) begin
          state <= StActive;
          cnt   <= CntW'(wid_i) - CntOne;
          q_r   <= 1'b1;
        end else begin
          state <= StDelay;
          cnt   <= CntW'(dly_i) - CntOne;
          q_r   <= 1'b0;
        end
      end else begin
        unique case (state)
          StDelay: begin
            if (cnt == '0) begin
              state <= StActive;
              cnt   <= CntW'(wid_lat) - CntOne;
              q_r   <= 1'b1;
            end else begin
              cnt <= cnt - CntOne;
            end
          end
          StActive: begin
            if (cnt == '0) begin
              state  <= StIdle;
              q_r    <= 1'b0;
              busy_r <= 1'b0;
            end else begin
              cnt <= cnt - CntOne;
            end
          end
          StIdle: ;
          default: begin
            state  <= StIdle;
            q_r    <= 1'b0;
            busy_r <= 1'b0;
          end
        endcase
      end
    end

    assign q[i]    = q_r;
    assign busy[i] = busy_r;

`ifdef PULSE_SCHED_OVR_EN
    logic drop;
    logic ovr_r;

    assign drop = trig && (state != StIdle) && !retrig[i];

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovr_r <= 1'b0;
      end else if (drop) begin
        ovr_r <= 1'b1;
      end else if (ovr_clr[i]) begin
        ovr_r <= 1'b0;
      end
    end

    assign ovr[i] = ovr_r;
`else
    assign ovr[i] = 1'b0;
`endif
  end

`ifndef PULSE_SCHED_OVR_EN
  logic unused_ovr_clr;
  assign unused_ovr_clr = ^ovr_clr;
`endif

endmodule
